// File: rtl/vram_pkg.sv
// Shared constants, opcodes and loader state encoding for the VRAM loader slice.
package vram_pkg;

  localparam int VRAM_DEPTH  = 16000;
  localparam int VRAM_ADDR_W = 14;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SETADDR = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_FILL    = 8'h03;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_FILL_VAL,
    ST_FILLING,
    ST_CLEAR
  } vram_state_t;

endpackage

// File: rtl/vram_dp.sv
// Simple dual-port byte RAM: one write port, one registered read port (read-before-write).
// Reads beyond the populated depth return 0.
module vram_dp #(
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [7:0] r_mem [0:DEPTH-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Non-blocking semantics give the pre-write value on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset)                 r_rdata <= 8'h00;
    else if (i_raddr <= LAST)  r_rdata <= r_mem[i_raddr];
    else                       r_rdata <= 8'h00;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vram_loader.sv
// Byte-stream command loader owning the scan-out VRAM (SETADDR / WRITE / FILL).
// Define VRAM_CLEAR_ON_RESET_EN to zero the whole VRAM after every reset.
// Handshake: a byte moves on a pclk edge with in_valid && in_ready; in_ready is registered.
module vram_loader
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              cmd_err,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output vram_state_t       o_dbg_state,
  output logic [ADDR_W-1:0] o_dbg_wr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  vram_state_t       r_state;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_len;
  logic              r_is_fill;
  logic [7:0]        r_addr_hi;
  logic [7:0]        r_fill_val;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_cmd_err;

  vram_state_t       w_next_state;
  logic              w_take;
  logic              w_we;
  logic [7:0]        w_wdata;
  logic [ADDR_W-1:0] w_addr_inc;
  logic [ADDR_W-1:0] w_set_addr;
  logic              w_bad_op;

  assign w_take     = in_valid && r_in_ready;
  assign w_addr_inc = (r_wr_addr == LAST) ? '0 : r_wr_addr + 1'b1;
  assign w_set_addr = ADDR_W'({r_addr_hi, in_data});
  assign w_bad_op   = !(in_data inside {OP_NOP, OP_SETADDR, OP_WRITE, OP_FILL});

  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wdata      = 8'h00;
    case (r_state)
      ST_IDLE: if (w_take) begin
        if (in_data == OP_SETADDR)                           w_next_state = ST_ADDR_HI;
        else if (in_data == OP_WRITE || in_data == OP_FILL)  w_next_state = ST_LEN_HI;
      end
      ST_ADDR_HI:  if (w_take) w_next_state = ST_ADDR_LO;
      ST_ADDR_LO:  if (w_take) w_next_state = ST_IDLE;
      ST_LEN_HI:   if (w_take) w_next_state = ST_LEN_LO;
      ST_LEN_LO: if (w_take) begin
        if ({r_len[15:8], in_data} == 16'd0) w_next_state = ST_IDLE;
        else if (r_is_fill)                  w_next_state = ST_FILL_VAL;
        else                                 w_next_state = ST_DATA;
      end
      ST_DATA: if (w_take) begin
        w_we    = 1'b1;
        w_wdata = in_data;
        if (r_len == 16'd1) w_next_state = ST_IDLE;
      end
      ST_FILL_VAL: if (w_take) w_next_state = ST_FILLING;
      ST_FILLING: begin
        w_we    = 1'b1;
        w_wdata = r_fill_val;
        if (r_len == 16'd1) w_next_state = ST_IDLE;
      end
      ST_CLEAR: begin
        w_we = 1'b1;
        if (r_wr_addr == LAST) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
`ifdef VRAM_CLEAR_ON_RESET_EN
      r_state    <= ST_CLEAR;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
`else
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
`endif
      r_wr_addr  <= '0;
      r_len      <= 16'd0;
      r_is_fill  <= 1'b0;
      r_addr_hi  <= 8'h00;
      r_fill_val <= 8'h00;
      r_cmd_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= !(w_next_state == ST_FILLING || w_next_state == ST_CLEAR);
      r_busy     <= (w_next_state != ST_IDLE);
      r_cmd_err  <= w_take && (r_state == ST_IDLE) && w_bad_op;
      if (w_we) r_wr_addr <= w_addr_inc;
      case (r_state)
        ST_IDLE:     if (w_take) r_is_fill <= (in_data == OP_FILL);
        ST_ADDR_HI:  if (w_take) r_addr_hi <= in_data;
        ST_ADDR_LO:  if (w_take) r_wr_addr <= (w_set_addr > LAST) ? '0 : w_set_addr;
        ST_LEN_HI:   if (w_take) r_len[15:8] <= in_data;
        ST_LEN_LO:   if (w_take) r_len[7:0] <= in_data;
        ST_FILL_VAL: if (w_take) r_fill_val <= in_data;
        ST_DATA, ST_FILLING: if (w_we) r_len <= r_len - 16'd1;
        default: ;
      endcase
    end
  end

  vram_dp #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dp (
    .clk     (pclk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_wdata),
    .i_raddr (vid_addr),
    .o_rdata (vid_data)
  );

  assign in_ready      = r_in_ready;
  assign busy          = r_busy;
  assign cmd_err       = r_cmd_err;
  assign o_dbg_state   = r_state;
  assign o_dbg_wr_addr = r_wr_addr;

endmodule

// File: tb/tb_vram_loader.sv
// Directed bench for vram_loader: command decode, writes, fills with wrap, errors, reset, read port.
module tb_vram_loader;
  import vram_pkg::*;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        busy;
  logic        cmd_err;
  logic [13:0] vid_addr = 14'd0;
  logic [7:0]  vid_data;
  vram_state_t dbg_state;
  logic [13:0] dbg_wr_addr;

  int errors = 0;
  int checks = 0;

  always #5 pclk = ~pclk;

  vram_loader dut (
    .pclk          (pclk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .busy          (busy),
    .cmd_err       (cmd_err),
    .vid_addr      (vid_addr),
    .vid_data      (vid_data),
    .o_dbg_state   (dbg_state),
    .o_dbg_wr_addr (dbg_wr_addr)
  );

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge pclk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20000) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 20000) begin
      checks++; errors++;
      $display("FAIL send_timeout byte=%02h in_ready stayed 0 for %0d cycles", b, n);
    end
    @(posedge pclk);
    #1 in_valid = 1'b0;
  endtask

  task automatic read_vram(input logic [13:0] a, output logic [7:0] d);
    @(negedge pclk);
    vid_addr = a;
    @(posedge pclk);
    #1 d = vid_data;
  endtask

  task automatic count_not_ready(output int n);
    n = 0;
    @(negedge pclk);
    while (!in_ready && n < 20000) begin
      n++;
      @(negedge pclk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge pclk);
    reset = 1'b1;
    @(posedge pclk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_clear_done();
`ifdef VRAM_CLEAR_ON_RESET_EN
    int n;
    count_not_ready(n);
    checks++;
    if (n != 16000) begin
      errors++;
      $display("FAIL clear_len not_ready_cycles=%0d expected=16000", n);
    end
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (vid_data !== 8'h00 || cmd_err !== 1'b0 || dbg_wr_addr !== 14'd0) begin
      errors++;
      $display("FAIL reset_vals vid_data=%02h cmd_err=%b wr_addr=%0d expected 00 0 0",
               vid_data, cmd_err, dbg_wr_addr);
    end
    checks++;
`ifdef VRAM_CLEAR_ON_RESET_EN
    if (dbg_state !== ST_CLEAR || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_clear state=%0d in_ready=%b busy=%b expected CLEAR 0 1",
               dbg_state, in_ready, busy);
    end
`else
    if (dbg_state !== ST_IDLE || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle state=%0d in_ready=%b busy=%b expected IDLE 1 0",
               dbg_state, in_ready, busy);
    end
`endif
    @(negedge pclk);
    reset = 1'b0;
    wait_clear_done();
  endtask

  task automatic test_clear();
`ifdef VRAM_CLEAR_ON_RESET_EN
    logic [7:0] d;
    logic [13:0] addrs [3];
    addrs = '{14'd0, 14'd7999, 14'd15999};
    foreach (addrs[i]) begin
      read_vram(addrs[i], d);
      checks++;
      if (d !== 8'h00) begin
        errors++;
        $display("FAIL clear_data addr=%0d got=%02h expected=00", addrs[i], d);
      end
    end
    checks++;
    if (dbg_wr_addr !== 14'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_exit wr_addr=%0d busy=%b expected 0 0", dbg_wr_addr, busy);
    end
`endif
  endtask

  task automatic test_write();
    logic [7:0] d;
    logic [7:0] exp_d [3];
    exp_d = '{8'hE0, 8'h1C, 8'h03};
    send_byte(OP_SETADDR);
    checks++;
    if (busy !== 1'b1 || dbg_state !== ST_ADDR_HI) begin
      errors++;
      $display("FAIL write_busy busy=%b state=%0d expected 1 ADDR_HI", busy, dbg_state);
    end
    send_byte(8'h00); send_byte(8'h10);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'hE0); send_byte(8'h1C); send_byte(8'h03);
    checks++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE || dbg_wr_addr !== 14'd19) begin
      errors++;
      $display("FAIL write_done busy=%b state=%0d wr_addr=%0d expected 0 IDLE 19",
               busy, dbg_state, dbg_wr_addr);
    end
    for (int i = 0; i < 3; i++) begin
      read_vram(14'(16 + i), d);
      checks++;
      if (d !== exp_d[i]) begin
        errors++;
        $display("FAIL write_data addr=%0d got=%02h expected=%02h", 16 + i, d, exp_d[i]);
      end
    end
  endtask

  task automatic test_fill_wrap();
    logic [7:0] d;
    int n;
    logic [13:0] addrs [4];
    addrs = '{14'd15998, 14'd15999, 14'd0, 14'd1};
    send_byte(OP_SETADDR); send_byte(8'h3E); send_byte(8'h7E);
    send_byte(OP_FILL); send_byte(8'h00); send_byte(8'h04); send_byte(8'hFF);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_start busy=%b in_ready=%b expected 1 0", busy, in_ready);
    end
    count_not_ready(n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL fill_ready_low cycles=%0d expected=4", n);
    end
    checks++;
    if (dbg_wr_addr !== 14'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fill_end wr_addr=%0d busy=%b expected 2 0", dbg_wr_addr, busy);
    end
    foreach (addrs[i]) begin
      read_vram(addrs[i], d);
      checks++;
      if (d !== 8'hFF) begin
        errors++;
        $display("FAIL fill_data addr=%0d got=%02h expected=FF", addrs[i], d);
      end
    end
  endtask

  task automatic test_bad_opcode();
    send_byte(8'h7A);
    checks++;
    if (cmd_err !== 1'b1 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL badop_pulse cmd_err=%b state=%0d expected 1 IDLE", cmd_err, dbg_state);
    end
    @(posedge pclk); #1;
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL badop_width cmd_err=%b expected 0", cmd_err);
    end
    send_byte(OP_SETADDR); send_byte(8'h00); send_byte(8'h20);
    checks++;
    if (dbg_wr_addr !== 14'h20 || busy !== 1'b0 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL badop_next wr_addr=%0d busy=%b cmd_err=%b expected 32 0 0",
               dbg_wr_addr, busy, cmd_err);
    end
  endtask

  task automatic test_setaddr_clamp();
    logic [7:0]  hi_v [4];
    logic [7:0]  lo_v [4];
    logic [13:0] exp_a [4];
    hi_v  = '{8'h3E, 8'h3E, 8'hFF, 8'h7E};
    lo_v  = '{8'h7F, 8'h80, 8'hFF, 8'h7F};
    exp_a = '{14'd15999, 14'd0, 14'd0, 14'd15999};
    for (int i = 0; i < 4; i++) begin
      send_byte(OP_SETADDR); send_byte(hi_v[i]); send_byte(lo_v[i]);
      checks++;
      if (dbg_wr_addr !== exp_a[i]) begin
        errors++;
        $display("FAIL setaddr_clamp in=%02h%02h wr_addr=%0d expected=%0d",
                 hi_v[i], lo_v[i], dbg_wr_addr, exp_a[i]);
      end
    end
  endtask

  task automatic test_len_zero();
    logic [7:0] d;
    send_byte(OP_SETADDR); send_byte(8'h00); send_byte(8'h28);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h01); send_byte(8'h55);
    send_byte(OP_SETADDR); send_byte(8'h00); send_byte(8'h28);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h00);
    checks++;
    if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle state=%0d busy=%b expected IDLE 0", dbg_state, busy);
    end
    send_byte(OP_SETADDR);
    checks++;
    if (dbg_state !== ST_ADDR_HI) begin
      errors++;
      $display("FAIL len0_next_op state=%0d expected ADDR_HI", dbg_state);
    end
    send_byte(8'h00); send_byte(8'h30);
    read_vram(14'd40, d);
    checks++;
    if (d !== 8'h55 || dbg_wr_addr !== 14'd48) begin
      errors++;
      $display("FAIL len0_nochange data=%02h wr_addr=%0d expected 55 48", d, dbg_wr_addr);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    logic [7:0] exp_keep;
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h03); send_byte(8'hAA);
    pulse_reset();
`ifdef VRAM_CLEAR_ON_RESET_EN
    exp_keep = 8'h00;
    wait_clear_done();
`else
    exp_keep = 8'hAA;
`endif
    checks++;
    if (dbg_state !== ST_IDLE || in_ready !== 1'b1 || dbg_wr_addr !== 14'd0) begin
      errors++;
      $display("FAIL midrst_idle state=%0d in_ready=%b wr_addr=%0d expected IDLE 1 0",
               dbg_state, in_ready, dbg_wr_addr);
    end
    send_byte(OP_SETADDR);
    checks++;
    if (dbg_state !== ST_ADDR_HI || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_decode state=%0d busy=%b expected ADDR_HI 1", dbg_state, busy);
    end
    send_byte(8'h00); send_byte(8'h05);
    read_vram(14'd48, d);
    checks++;
    if (d !== exp_keep) begin
      errors++;
      $display("FAIL midrst_keep data=%02h expected=%02h", d, exp_keep);
    end
  endtask

  task automatic test_read_before_write();
    send_byte(OP_SETADDR); send_byte(8'h00); send_byte(8'h05);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h01); send_byte(8'h11);
    send_byte(OP_SETADDR); send_byte(8'h00); send_byte(8'h05);
    send_byte(OP_WRITE); send_byte(8'h00); send_byte(8'h01);
    @(negedge pclk);
    vid_addr = 14'd5;
    in_valid = 1'b1;
    in_data  = 8'h22;
    @(posedge pclk);
    #1 in_valid = 1'b0;
    checks++;
    if (vid_data !== 8'h11) begin
      errors++;
      $display("FAIL rbw_old got=%02h expected=11", vid_data);
    end
    @(posedge pclk); #1;
    checks++;
    if (vid_data !== 8'h22) begin
      errors++;
      $display("FAIL rbw_new got=%02h expected=22", vid_data);
    end
  endtask

  task automatic test_oob_read();
    logic [7:0] d;
    read_vram(14'd16000, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL oob_16000 got=%02h expected=00", d);
    end
    read_vram(14'd16383, d);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("FAIL oob_16383 got=%02h expected=00", d);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write();
    test_fill_wrap();
    test_bad_opcode();
    test_setaddr_clamp();
    test_len_zero();
    test_reset_mid_write();
    test_read_before_write();
    test_oob_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
